// File: rtl/spike_acc_pkg.sv
// Shared FSM state encoding and default sizing for the spike accumulator.
// Optional leak is enabled with SPIKE_ACC_LEAK_EN (see spike_accumulator).
package spike_acc_pkg;

  typedef enum logic [1:0] {
    S_RECV = 2'd0,
    S_RACK = 2'd1,
    S_SEND = 2'd2,
    S_SACK = 2'd3
  } state_e;

  localparam int WIDTH_DEF     = 8;
  localparam int NUM_IN_DEF    = 5;
  localparam int ACC_W_DEF     = 13;
  localparam int THRESHOLD_DEF = 64;
  localparam int LEAK_DEF      = 4;

endpackage

// File: rtl/sat_add.sv
// Unsigned adder that clamps the sum at the all-ones ACC_W value.
// Never wraps, whatever the operand widths.
module sat_add #(
  parameter int IN_W  = 9,
  parameter int ACC_W = 13
) (
  input  logic [ACC_W-1:0] acc_i,
  input  logic [IN_W-1:0]  add_i,
  output logic [ACC_W-1:0] sum_o
);

  localparam int SW = ((IN_W > ACC_W) ? IN_W : ACC_W) + 1;

  logic [SW-1:0] full;
  logic [SW-1:0] max_v;

  always_comb begin
    full  = SW'(acc_i) + SW'(add_i);
    max_v = SW'({ACC_W{1'b1}});
    if (full > max_v) begin
      sum_o = {ACC_W{1'b1}};
    end else begin
      sum_o = full[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/spike_accumulator.sv
// Integrate NUM_IN partial sums per timestep, fire on threshold.
// Define SPIKE_ACC_LEAK_EN to leak LEAK per non-spiking timestep.
module spike_accumulator
  import spike_acc_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_IN    = NUM_IN_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int LEAK      = LEAK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_req,
  input  logic [WIDTH:0]   in_data,
  output logic             in_ack,
  output logic             out_req,
  output logic             out_spike,
  output logic [ACC_W-1:0] out_potential,
  input  logic             out_ack
);

  localparam int CW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam logic [CW-1:0]    LAST   = CW'(NUM_IN - 1);
  localparam logic [ACC_W-1:0] THR_V  = ACC_W'(THRESHOLD);
  localparam logic [ACC_W-1:0] LEAK_V = ACC_W'(LEAK);

`ifdef SPIKE_ACC_LEAK_EN
  localparam bit LEAK_EN = 1'b1;
`else
  localparam bit LEAK_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] pot_q, pot_d;
  logic             spike_q, spike_d;
  logic [ACC_W-1:0] opot_q, opot_d;

  logic [ACC_W-1:0] pot_sum;
  logic [ACC_W-1:0] pot_rest;
  logic             fire;

  sat_add #(
    .IN_W  (WIDTH + 1),
    .ACC_W (ACC_W)
  ) u_sat_add (
    .acc_i (pot_q),
    .add_i (in_data),
    .sum_o (pot_sum)
  );

  always_comb begin
    fire     = (pot_q >= THR_V);
    pot_rest = pot_q;
    if (LEAK_EN) begin
      pot_rest = (pot_q >= LEAK_V) ? (pot_q - LEAK_V) : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pot_d   = pot_q;
    spike_d = spike_q;
    opot_d  = opot_q;
    unique case (state_q)
      S_RECV: begin
        if (in_req) begin
          pot_d   = pot_sum;
          state_d = S_RACK;
        end
      end
      S_RACK: begin
        if (!in_req) begin
          if (cnt_q == LAST) begin
            spike_d = fire;
            opot_d  = pot_q;
            pot_d   = fire ? '0 : pot_rest;
            cnt_d   = '0;
            state_d = S_SEND;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_RECV;
          end
        end
      end
      S_SEND: begin
        if (out_ack) state_d = S_SACK;
      end
      S_SACK: begin
        if (!out_ack) state_d = S_RECV;
      end
      default: state_d = S_RECV;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RECV;
      cnt_q   <= '0;
      pot_q   <= '0;
      spike_q <= 1'b0;
      opot_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pot_q   <= pot_d;
      spike_q <= spike_d;
      opot_q  <= opot_d;
    end
  end

  // Handshake outputs are pure state decodes, so reset clears them at once.
  assign in_ack        = (state_q == S_RACK);
  assign out_req       = (state_q == S_SEND);
  assign out_spike     = spike_q;
  assign out_potential = opot_q;

endmodule

// File: tb/tb_spike_accumulator.sv
// Randomized bench for spike_accumulator against a per-timestep model.
// Two instances: THRESHOLD=64 and THRESHOLD=8191, selected by sel.
module tb_spike_accumulator;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int AW = 13;
  localparam int PMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sel = 1'b0;
  logic          in_req = 1'b0;
  logic          out_ack = 1'b0;
  logic [W:0]    in_data = '0;

  logic          ack0, ack1, oreq0, oreq1, sp0, sp1;
  logic [AW-1:0] op0, op1;
  logic          in_ack, oreq, spike;
  logic [AW-1:0] opot;

  always #5 clk = ~clk;

  assign in_ack = sel ? ack1  : ack0;
  assign oreq   = sel ? oreq1 : oreq0;
  assign spike  = sel ? sp1   : sp0;
  assign opot   = sel ? op1   : op0;

  spike_accumulator #(
    .WIDTH(W), .NUM_IN(N), .ACC_W(AW), .THRESHOLD(64), .LEAK(4)
  ) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_req        (in_req & !sel),
    .in_data       (in_data),
    .in_ack        (ack0),
    .out_req       (oreq0),
    .out_spike     (sp0),
    .out_potential (op0),
    .out_ack       (out_ack & !sel)
  );

  spike_accumulator #(
    .WIDTH(W), .NUM_IN(N), .ACC_W(AW), .THRESHOLD(8191), .LEAK(4)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_req        (in_req & sel),
    .in_data       (in_data),
    .in_ack        (ack1),
    .out_req       (oreq1),
    .out_spike     (sp1),
    .out_potential (op1),
    .out_ack       (out_ack & sel)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int mpot[2] = '{0, 0};
  int thr[2]  = '{64, 8191};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic send_sum(input int d);
    @(negedge clk);
    in_data = (W+1)'(d);
    in_req  = 1'b1;
    @(posedge clk); #1;
    check("in_ack_rise", in_ack, 1);
    mpot[sel] = (mpot[sel] + d > PMAX) ? PMAX : mpot[sel] + d;
    in_req = 1'b0;
    @(posedge clk); #1;
    check("in_ack_fall", in_ack, 0);
  endtask

  // mode 0: all 10, 1: full range, 2: small, 3: all max
  task automatic timestep(input int mode, input int stall);
    int d, exp_pot;
    bit fire;
    for (int i = 0; i < N; i++) begin
      case (mode)
        0:       d = 10;
        1:       d = (i == 0) ? 511 : int'($urandom_range(0, 511));
        2:       d = int'($urandom_range(0, 16));
        default: d = 511;
      endcase
      send_sum(d);
    end
    exp_pot = mpot[sel];
    fire    = (exp_pot >= thr[sel]);
    if (fire) mpot[sel] = 0;
`ifdef SPIKE_ACC_LEAK_EN
    else mpot[sel] = (mpot[sel] > 4) ? mpot[sel] - 4 : 0;
`endif
    check("out_req_rise", oreq, 1);
    check("out_spike", spike, 32'(fire));
    check("out_potential", opot, exp_pot);
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      in_req = 1'b1;
      in_data = '1;
      @(posedge clk); #1;
      check("hold_req", oreq, 1);
      check("hold_spike", spike, 32'(fire));
      check("hold_pot", opot, exp_pot);
      check("bp_in_ack", in_ack, 0);
    end
    @(negedge clk);
    in_req  = 1'b0;
    out_ack = 1'b1;
    @(posedge clk); #1;
    check("out_req_fall", oreq, 0);
    check("sack_pot", opot, exp_pot);
    @(negedge clk);
    out_ack = 1'b0;
    @(posedge clk); #1;
    check("sack_exit_ack", in_ack, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ack", in_ack, 0);
    check("rst_out_req", oreq, 0);
    check("rst_spike", spike, 0);
    check("rst_pot", opot, 0);
    @(negedge clk);
    rst_n = 1'b1;

    timestep(0, 0);
    timestep(0, 10);

    // Reset in the middle of the third sum's acknowledge phase
    send_sum(10);
    send_sum(10);
    @(negedge clk);
    in_data = 9'd10;
    in_req  = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ack", in_ack, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ack", in_ack, 0);
    check("async_rst_req", oreq, 0);
    in_req = 1'b0;
    mpot[0] = 0;
    mpot[1] = 0;
    @(negedge clk);
    rst_n = 1'b1;
    timestep(0, 0);

    repeat (12) timestep(int'($urandom_range(1, 2)), int'($urandom_range(0, 3)));

    sel = 1'b1;
    repeat (4) timestep(3, 0);
    repeat (3) timestep(1, int'($urandom_range(0, 2)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spike_accumulator.md
SPIKE_ACCUMULATOR -- requirements
Module: spike_accumulator

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the adder operand width; each input partial sum is WIDTH+1 bits.
REQ-002 The block SHALL have parameter NUM_IN, default 5, giving the number of partial sums per timestep.
REQ-003 The block SHALL have parameter ACC_W, default 13, giving the potential register width.
REQ-004 The block SHALL have parameter THRESHOLD, default 64, giving the firing threshold (unsigned, ACC_W bits).
REQ-005 The block SHALL have parameter LEAK, default 4, giving the per-timestep leak (used only with SPIKE_ACC_LEAK_EN).
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic on rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port in_req, input, 1 bit: 4-phase bundled-data request from the two-input adder, synchronous to clk.
REQ-009 The block SHALL have port in_data, input, WIDTH+1 bits: unsigned partial sum, valid while in_req=1.
REQ-010 The block SHALL have port in_ack, output, 1 bit: 4-phase acknowledge to the adder.
REQ-011 The block SHALL have port out_req, output, 1 bit: 4-phase request to the downstream consumer.
REQ-012 The block SHALL have port out_spike, output, 1 bit: fire flag for the timestep.
REQ-013 The block SHALL have port out_potential, output, ACC_W bits: potential compared against THRESHOLD.
REQ-014 The block SHALL have port out_ack, input, 1 bit: 4-phase acknowledge from downstream, synchronous to clk.

Function
REQ-015 The FSM SHALL have states S_RECV (wait in_req=1), S_RACK (in_ack=1, wait in_req=0), S_SEND (out_req=1, wait out_ack=1) and S_SACK (out_req=0, wait out_ack=0).
REQ-016 In S_RECV, at an edge sampling in_req=1, the block SHALL add in_data to the potential with saturation at 2^ACC_W-1, set in_ack=1 and enter S_RACK.
REQ-017 In S_RACK, at an edge sampling in_req=0, the block SHALL set in_ack=0; if cnt<NUM_IN-1 it SHALL increment cnt and return to S_RECV.
REQ-018 In S_RACK with cnt==NUM_IN-1, at the same edge the block SHALL register out_spike=(potential>=THRESHOLD) and out_potential=potential, set out_req=1, clear cnt and enter S_SEND.
REQ-019 Output latency SHALL be one clk edge from sampling the final in_req falling; in_ack latency SHALL be one edge from each in_req transition.
REQ-020 On a spike, the potential SHALL reset to 0 at the S_SEND-entry edge; otherwise it SHALL be retained.
REQ-021 In S_SEND, at an edge sampling out_ack=1, the block SHALL set out_req=0 and enter S_SACK; in S_SACK, at out_ack=0, it SHALL enter S_RECV.
REQ-022 out_spike and out_potential SHALL be held stable from out_req rising until the S_SACK exit.
REQ-023 While in S_SEND or S_SACK, in_ack SHALL stay 0 and in_req SHALL be ignored (backpressure).
REQ-024 in_data=2^(WIDTH+1)-1 SHALL be accumulated without overflow wrap; the potential SHALL never wrap.

Reset
REQ-025 While rst_n=0, the block SHALL hold state S_RECV, in_ack=0, out_req=0, out_spike=0, out_potential=0, potential=0 and cnt=0, including when reset is asserted mid-handshake.

Configuration
REQ-026 With SPIKE_ACC_LEAK_EN defined, a non-spiking timestep SHALL set potential=max(potential-LEAK,0) at the S_SEND-entry edge; without it, the potential SHALL be retained unchanged.

Structure
REQ-027 Package spike_acc_pkg SHALL hold the FSM state enum and default parameter constants.
REQ-028 Saturating addition SHALL be a sub-module sat_add (parameters IN_W, ACC_W).

Verification
REQ-029 Five sums of 10 -> out_spike=0, out_potential=50; next five of 10 -> out_spike=1, out_potential=100; potential then 0.
REQ-030 With SPIKE_ACC_LEAK_EN, five sums of 10 -> out_potential=50, internal potential 46; next five of 10 -> out_potential=96, spike=1.
REQ-031 With THRESHOLD=8191, four timesteps of five sums of 511 -> out_potential 2555, 5110, 7665, then 8191 with spike=1.
REQ-032 out_ack held 0 for 10 cycles after out_req=1 -> out_req, out_spike, out_potential stable, in_ack remains 0 despite in_req=1.
REQ-033 rst_n pulled low during S_RACK of the third sum -> in_ack=0 immediately; the next five sums of 10 give out_potential=50.
